tt_um_serial_deser: RTL and testbench

- Serial-to-parallel receiver: the listening end of the serial link that our universal shift register drives when shifting out.
- Recovers framed async bytes (start bit, 8 data bits, stop bit) from one line, MSB-first or LSB-first, and presents them on the TinyTapeOut pins.
- Byte output carries valid, framing-error and overrun flags; host acknowledges reads.

---
 rtl/tt_um_serial_deser.sv | 194 +++++++++++++++++++
 tb/tb_tt_um_serial_deser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_deser.sv
// Purpose : async serial byte receiver (start, 8 data, [parity], stop) -> TinyTapeOut pins.
// Latency : byte and valid appear one clk after the mid-stop-bit sample (plus SYNC_STAGES input delay).
// Backpressure: none on the line; an unread byte (valid=1, no ack) causes later good bytes to be dropped with overrun.
//
// Ports:
//   clk, rst_n (synchronous, active-low), ena (0 freezes everything)
//   ui_in[0] sin (idle high), ui_in[1] dir (0 MSB-first, 1 LSB-first), ui_in[2] ack (level)
//   uo_out   last good byte
//   uio_out  [0] valid [1] frame_err [2] overrun [3] busy [4] parity_err
//   uio_oe   constant 8'h1F
// Optional build macro PARITY_EN adds an even-parity bit between data and stop.
module tt_um_serial_deser #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // S_PAR is only visited when PARITY_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE
    } state_t;

    localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

    logic                   sin, dir, ack, line;
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   dir_q, dir_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   perr_q, perr_d;
    logic                   pbad_q, pbad_d;   // parity failed for the frame in flight
    logic                   bit_done;
    logic                   unused_in;

    assign sin       = ui_in[0];
    assign dir       = ui_in[1];
    assign ack       = ui_in[2];
    assign line      = sync_q[SYNC_STAGES-1];
    assign bit_done  = (cnt_q == BIT_M1);
    assign unused_in = ^{uio_in, ui_in[7:3]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '1;      // idle-high, so reset never looks like a start bit
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            dir_q     <= 1'b0;
            shreg_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
            pbad_q    <= 1'b0;
        end else if (ena) begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
            end else begin
                sync_q <= sin;
            end
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            dir_q     <= dir_d;
            shreg_q   <= shreg_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            perr_q    <= perr_d;
            pbad_q    <= pbad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        dir_d     = dir_q;
        shreg_d   = shreg_q;
        byte_d    = byte_q;
        pbad_d    = pbad_q;
        // ack clears first; any flag set below in the same cycle overrides it
        valid_d   = valid_q & ~ack;
        ferr_d    = ferr_q  & ~ack;
        ovr_d     = ovr_q   & ~ack;
        perr_d    = perr_q  & ~ack;

        case (state_q)
            S_IDLE: begin
                if (!line) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    if (!line) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        dir_d     = dir;
                        pbad_d    = 1'b0;
                    end else begin
                        state_d   = S_IDLE;   // glitch, silently ignored
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shreg_d = dir_q ? {line, shreg_q[7:1]} : {shreg_q[6:0], line};
                    if (bit_idx_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    // even parity: XOR of data and parity bit must be 0 (order-independent)
                    if (^{shreg_q, line}) begin
                        pbad_d = 1'b1;
                        perr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!line) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_IDLE;
                        if (!pbad_q) begin
                            // an ack this cycle frees the holding register, so the load wins
                            if (!valid_q || ack) begin
                                byte_d  = shreg_q;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_IDLE: begin
                if (line) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign uo_out  = byte_q;
    assign uio_out = {3'b000, perr_q, (state_q != S_IDLE), ovr_q, ferr_q, valid_q};
    assign uio_oe  = 8'b0001_1111;

endmodule

// File: tb/tb_tt_um_serial_deser.sv
`timescale 1ns/1ps
module tb_tt_um_serial_deser;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sin = 1'b1, dir = 1'b0, ack = 1'b0;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    assign ui_in = {5'b0, ack, dir, sin};

    tt_um_serial_deser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    bit  settled = 1'b0;
    bit  rand_ena = 1'b0;

    // behavioural model: what the host should see once the line is idle
    logic [7:0] m_byte;
    bit         m_valid, m_ferr, m_ovr, m_perr;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (settled) begin
            chk("uo_out",     uo_out,     m_byte);
            chk("valid",      {7'b0, uio_out[0]}, {7'b0, m_valid});
            chk("frame_err",  {7'b0, uio_out[1]}, {7'b0, m_ferr});
            chk("overrun",    {7'b0, uio_out[2]}, {7'b0, m_ovr});
            chk("busy_idle",  {7'b0, uio_out[3]}, 8'h00);
            chk("parity_err", {7'b0, uio_out[4]}, {7'b0, m_perr});
            chk("uio_hi",     {5'b0, uio_out[7:5]}, 8'h00);
            chk("uio_oe",     uio_oe, 8'h1F);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold the line for n enabled clocks; optional random ena stalls
    task automatic hold_bit(input int n);
        int k;
        k = 0;
        while (k < n) begin
            ena = !(rand_ena && ($urandom_range(0, 7) == 0));
            tick();
            if (ena) k++;
        end
        ena = 1'b1;
    endtask

    task automatic model_clear();
        m_valid = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    // what a complete frame does to the host-visible state
    task automatic model_frame(input logic [7:0] s, input bit d, input bit pbit, input bit stop_bit);
        logic [7:0] b;
        bit         pbad;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (d == 1'b0) b = 8'((b << 1) | 8'(s[i]));
            else           b = b | 8'(s[i] << i);
        end
        pbad = 1'b0;
`ifdef PARITY_EN
        pbad = ((s[0]+s[1]+s[2]+s[3]+s[4]+s[5]+s[6]+s[7]+pbit) % 2) != 0;
        if (pbad) m_perr = 1;
`else
        if (pbit) pbad = 1'b0;
`endif
        if (!stop_bit) m_ferr = 1;
        else if (!pbad) begin
            if (!m_valid) begin
                m_byte  = b;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // lsb_enc selects the wire order of the data bits; dir_flip_at changes dir before that data bit
    task automatic send_frame(input logic [7:0] data, input bit lsb_enc, input bit stop_bit,
                              input bit par_flip, input int dir_flip_at);
        logic [7:0] s;
        bit         d0, pbit;
        for (int i = 0; i < 8; i++) s[i] = lsb_enc ? data[i] : data[7-i];
        pbit = (^s) ^ par_flip;
        d0 = dir;
        settled = 1'b0;
        sin = 1'b0;
        hold_bit(CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == dir_flip_at) dir = ~dir;
            sin = s[i];
            hold_bit(CPB);
        end
`ifdef PARITY_EN
        sin = pbit;
        hold_bit(CPB);
`endif
        sin = stop_bit;
        hold_bit(CPB);
        if (!stop_bit) begin
            hold_bit(40);
        end
        sin = 1'b1;
        model_frame(s, d0, pbit, stop_bit);
        hold_bit(20);
        settled = 1'b1;
        tick();
    endtask

    task automatic do_ack();
        settled = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        model_clear();
        tick();
        settled = 1'b1;
        tick();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, saw_busy;
        uio_in = 8'hA5;
        m_byte = 8'h00;
        model_clear();

        // reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        settled = 1'b1;
        repeat (4) tick();

        // 0x12 MSB-first, dir=0
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, -1);
        chk("msb_12_uo", uo_out, 8'h12);
        chk("msb_12_flags", uio_out, 8'h01);

        // LSB-first stream, received MSB-first then LSB-first
        do_ack();
        send_frame(8'h12, 1'b1, 1'b1, 1'b0, -1);
        chk("lsb_stream_dir0", uo_out, 8'h48);
        do_ack();
        dir = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1, 1'b0, -1);
        chk("lsb_stream_dir1", uo_out, 8'h12);
        do_ack();
        dir = 1'b0;

        // start glitch: 4 clks low
        settled = 1'b0;
        sin = 1'b0;
        repeat (4) tick();
        sin = 1'b1;
        ok = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (uio_out[3]) saw_busy = 1'b1;
            else begin
                ok = 1'b1;
                break;
            end
        end
        chk("glitch_busy_seen", {7'b0, saw_busy}, 8'h01);
        chk("glitch_busy_clear", {7'b0, ok}, 8'h01);
        chk("glitch_flags", {5'b0, uio_out[2:0]}, 8'h00);
        settled = 1'b1;
        repeat (4) tick();

        // framing error then recovery
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1);
        chk("ferr_uo", uo_out, 8'h12);
        chk("ferr_flags", {5'b0, uio_out[2:0]}, 8'h02);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, -1);
        chk("after_ferr_uo", uo_out, 8'h33);
        chk("after_ferr_valid", {7'b0, uio_out[0]}, 8'h01);

        // overrun
        do_ack();
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1);
        chk("ovr_uo", uo_out, 8'hAA);
        chk("ovr_flags", {5'b0, uio_out[2:0]}, 8'h05);
        do_ack();
        chk("ack_flags", {5'b0, uio_out[2:0]}, 8'h00);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1);
        chk("third_uo", uo_out, 8'h55);

        // reset during data bit 4 of 0xFF
        settled = 1'b0;
        sin = 1'b0;
        hold_bit(CPB);
        sin = 1'b1;
        hold_bit(4 * CPB + 8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_byte = 8'h00;
        model_clear();
        chk("midrst_uo", uo_out, 8'h00);
        chk("midrst_uio", uio_out, 8'h00);
        hold_bit(3 * CPB);
        settled = 1'b1;
        tick();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1);
        chk("after_rst_uo", uo_out, 8'h81);
        chk("after_rst_valid", {7'b0, uio_out[0]}, 8'h01);

`ifdef PARITY_EN
        do_ack();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, -1);
        chk("par_good_valid", {7'b0, uio_out[0]}, 8'h01);
        do_ack();
        send_frame(8'h07, 1'b0, 1'b1, 1'b1, -1);
        chk("par_bad_flags", {3'b0, uio_out[4:0] & 5'b10111}, 8'h10);
`endif

        // randomized frames with ena stalls, mid-frame dir changes and sporadic acks
        rand_ena = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) do_ack();
            uio_in = 8'($urandom);
            dir = 1'($urandom_range(0, 1));
            send_frame(8'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 7)));
        end
        rand_ena = 1'b0;
        do_ack();

        settled = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
